boxcar_disc: RTL

BOXCAR_DISC -- requirements
Module: boxcar_disc

---
 rtl/boxcar_disc.sv | 139 +++++++++++++
 1 files changed

// File: rtl/boxcar_disc.sv
// Boxcar running-sum accumulator fed by a delay line (newest/oldest sample pair),
// followed by a threshold discriminator with holdoff and low-side hysteresis.
module boxcar_disc #(
    parameter int P_NBITS_DATA = 14,
    parameter int P_NBITS_ADDR = 8,
    parameter int P_NBITS_SUM  = P_NBITS_DATA + P_NBITS_ADDR
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [P_NBITS_DATA-1:0] qo,
    input  logic                    valid_qo,
    input  logic [P_NBITS_DATA-1:0] qn,
    input  logic                    valid_qn,
    input  logic [P_NBITS_SUM-1:0]  thresh,
    input  logic [P_NBITS_ADDR-1:0] holdoff,
    output logic [P_NBITS_SUM-1:0]  sum,
    output logic                    sum_valid,
    output logic                    full,
    output logic                    trig,
    output logic                    armed
);

    typedef enum logic {
        ACC_FILL,
        ACC_RUN
    } acc_state_t;

    typedef enum logic [1:0] {
        DISC_ARMED,
        DISC_HOLD,
        DISC_WAIT_LOW
    } disc_state_t;

    acc_state_t              acc_q, acc_d;
    logic [P_NBITS_SUM-1:0]  sum_q, sum_d;
    logic                    sum_valid_q, sum_valid_d;

    disc_state_t             disc_q, disc_d;
    logic [P_NBITS_ADDR-1:0] cnt_q, cnt_d;
    logic                    trig_q, trig_d;

    logic [P_NBITS_SUM-1:0]  qo_ext;
    logic [P_NBITS_SUM-1:0]  qn_ext;
    logic                    above;

    assign qo_ext = P_NBITS_SUM'(qo);
    assign qn_ext = P_NBITS_SUM'(qn);
    assign above  = (sum_q > thresh);

    // Accumulator: the window grows until the delay line reports qn valid,
    // then slides; losing qn while sliding means the delay line re-primed.
    always_comb begin
        acc_d       = acc_q;
        sum_d       = sum_q;
        sum_valid_d = 1'b0;
        if (valid_qo) begin
            sum_valid_d = 1'b1;
            if (valid_qn) begin
                sum_d = sum_q + qo_ext - qn_ext;
                acc_d = ACC_RUN;
            end else if (acc_q == ACC_RUN) begin
                sum_d = qo_ext;
                acc_d = ACC_FILL;
            end else begin
                sum_d = sum_q + qo_ext;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= ACC_FILL;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    // Discriminator works on the registered sum; it only advances on sum updates
    // so idle input cycles freeze the holdoff count.
    always_comb begin
        disc_d = disc_q;
        cnt_d  = cnt_q;
        trig_d = 1'b0;
        if (acc_q != ACC_RUN) begin
            disc_d = DISC_ARMED;
            cnt_d  = '0;
        end else if (sum_valid_q) begin
            case (disc_q)
                DISC_ARMED: begin
                    if (above) begin
                        trig_d = 1'b1;
                        cnt_d  = holdoff;
                        disc_d = (holdoff != '0) ? DISC_HOLD : DISC_WAIT_LOW;
                    end
                end
                DISC_HOLD: begin
                    if (cnt_q <= P_NBITS_ADDR'(1)) begin
                        cnt_d  = '0;
                        disc_d = DISC_WAIT_LOW;
                    end else begin
                        cnt_d = cnt_q - P_NBITS_ADDR'(1);
                    end
                end
                DISC_WAIT_LOW: begin
                    if (!above) begin
                        disc_d = DISC_ARMED;
                    end
                end
                default: begin
                    disc_d = DISC_ARMED;
                    cnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disc_q <= DISC_ARMED;
            cnt_q  <= '0;
            trig_q <= 1'b0;
        end else begin
            disc_q <= disc_d;
            cnt_q  <= cnt_d;
            trig_q <= trig_d;
        end
    end

    assign sum       = sum_q;
    assign sum_valid = sum_valid_q;
    assign full      = (acc_q == ACC_RUN);
    assign trig      = trig_q;
    assign armed     = (disc_q == DISC_ARMED);

endmodule
